// File: rtl/pixel_compositor_pkg.sv
// Shared constants for the pixel compositor: game-state encodings,
// RGB332 field widths and the blanking colour.
package render_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_PLAY  = 2'b01,
        GS_P1WIN = 2'b10,
        GS_P2WIN = 2'b11
    } game_state_t;

    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    localparam logic [7:0] COLOR_BLACK = 8'h00;

endpackage

// File: rtl/pixel_compositor_if.sv
// Video bus between sprite generators, compositor and VGA pins.
// Inputs: video_on/hsync_in/vsync_in, layer_on/rgb/en, bg_rgb.
// Outputs: rgb_out, R/G/B split, delayed hsync/vsync/de.
interface pixel_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8
);
    import render_pkg::*;

    logic                          video_on;
    logic                          hsync_in;
    logic                          vsync_in;
    logic [NUM_LAYERS-1:0]         layer_on;
    logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb;
    logic [NUM_LAYERS-1:0]         layer_en;
    logic [COLOR_W-1:0]            bg_rgb;
    logic [COLOR_W-1:0]            rgb_out;
    logic [R_W-1:0]                R;
    logic [G_W-1:0]                G;
    logic [B_W-1:0]                B;
    logic                          hsync_out;
    logic                          vsync_out;
    logic                          de_out;

    modport master (
        output video_on, hsync_in, vsync_in,
        output layer_on, layer_rgb, layer_en, bg_rgb,
        input  rgb_out, R, G, B,
        input  hsync_out, vsync_out, de_out
    );

    modport slave (
        input  video_on, hsync_in, vsync_in,
        input  layer_on, layer_rgb, layer_en, bg_rgb,
        output rgb_out, R, G, B,
        output hsync_out, vsync_out, de_out
    );

endinterface

// File: rtl/pixel_compositor_blink_timer.sv
// Winner-screen blink timer: counts tick pulses while enabled and
// toggles phase every BLINK_MS ticks. Ports: clk, reset, tick, clear, enable -> phase.
module blink_timer #(
    parameter int BLINK_MS = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic clear,
    input  logic enable,
    output logic phase
);

    localparam int CNT_W = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_MS - 1);

    logic [CNT_W-1:0] count;

    // clear beats a coincident tick so a new state always starts visible
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            phase <= 1'b1;
        end else if (clear || !enable) begin
            count <= '0;
            phase <= 1'b1;
        end else if (tick) begin
            if (count == LAST) begin
                count <= '0;
                phase <= ~phase;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage sprite compositor: priority merge of layers, game-state mode
// select, blanking and sync/DE delay. Ports: clk, reset, tick_1ms, game_state, vid (slave).
module pixel_compositor
    import render_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 8,
    parameter int BLINK_MS   = 500
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1ms,
    input  logic [1:0]          game_state,
    pixel_compositor_if.slave   vid
);

    localparam int L1_IDX = (NUM_LAYERS < 2) ? 0 : 1;

    logic [NUM_LAYERS-1:0] hit;
    logic [COLOR_W-1:0]    chain [NUM_LAYERS+1];

    game_state_t        s1_state;
    logic               s1_de;
    logic               s1_hs;
    logic               s1_vs;
    logic               s1_any;
    logic [COLOR_W-1:0] s1_bg;
    logic [COLOR_W-1:0] s1_win;
    logic [COLOR_W-1:0] s1_l0;
    logic [COLOR_W-1:0] s1_l1;

    logic               phase;
    logic               state_chg;
    logic [COLOR_W-1:0] pix;

    assign hit = vid.layer_on & vid.layer_en;

    // lowest index wins: walk from the back so layer 0 overrides all
    assign chain[NUM_LAYERS] = vid.bg_rgb;
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_prio
        assign chain[i] = hit[i] ?
            vid.layer_rgb[i*COLOR_W +: COLOR_W] : chain[i+1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_state <= GS_IDLE;
            s1_de    <= 1'b0;
            s1_hs    <= 1'b1;
            s1_vs    <= 1'b1;
            s1_any   <= 1'b0;
            s1_bg    <= '0;
            s1_win   <= '0;
            s1_l0    <= '0;
            s1_l1    <= '0;
        end else begin
            s1_state <= game_state_t'(game_state);
            s1_de    <= vid.video_on;
            s1_hs    <= vid.hsync_in;
            s1_vs    <= vid.vsync_in;
            s1_any   <= |hit;
            s1_bg    <= vid.bg_rgb;
            s1_win   <= chain[0];
            s1_l0    <= vid.layer_rgb[0 +: COLOR_W];
            s1_l1    <= vid.layer_rgb[L1_IDX*COLOR_W +: COLOR_W];
        end
    end

    // timer updates alongside s1_state, so phase matches the state
    // the same pixel carries into stage 2
    assign state_chg = (game_state != s1_state);

    blink_timer #(
        .BLINK_MS (BLINK_MS)
    ) u_blink (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick_1ms),
        .clear  (state_chg),
        .enable (game_state[1]),
        .phase  (phase)
    );

    always_comb begin
        pix = s1_bg;
        unique case (s1_state)
            GS_IDLE:  pix = s1_bg;
            GS_PLAY:  pix = s1_any ? s1_win : s1_bg;
            GS_P1WIN: pix = phase ? s1_l0 : s1_bg;
            GS_P2WIN: pix = phase ? s1_l1 : s1_bg;
        endcase
        if (!s1_de) pix = COLOR_W'(COLOR_BLACK);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vid.rgb_out   <= '0;
            vid.de_out    <= 1'b0;
            vid.hsync_out <= 1'b1;
            vid.vsync_out <= 1'b1;
        end else begin
            vid.rgb_out   <= pix;
            vid.de_out    <= s1_de;
            vid.hsync_out <= s1_hs;
            vid.vsync_out <= s1_vs;
        end
    end

    assign vid.R = vid.rgb_out[COLOR_W-1 -: R_W];
    assign vid.G = vid.rgb_out[B_W +: G_W];
    assign vid.B = vid.rgb_out[0 +: B_W];

endmodule
